// File: rtl/wb_split_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_split_pkg
// Description : Shared types and constants for the Wishbone bus splitter.
//               The macro WB_SPLIT_TIMEOUT_EN (used by the splitter) enables
//               the hung-slave timeout and the status slot.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_split_pkg;

    localparam int WB_DATA_W = 32;

    // Decode field value reserved for the status register (field width is sliced by the user)
    localparam logic [31:0] STATUS_SLOT = 32'hFFFF_FFFF;

    localparam int TO_FLAG_BIT  = 0;
    localparam int LAST_IDX_LSB = 8;
    localparam int TMO_LSB      = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACTIVE = 3'd1,
        ST_UNMAP  = 3'd2,
        ST_STAT   = 3'd3,
        ST_TOUT   = 3'd4
    } wb_split_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_split_timeout.sv
`default_nettype none
// ============================================================================
// Module      : wb_split_timeout
// Description : Cycle counter for the splitter's hung-slave abort; expire is
//               raised in the enabled cycle where the count hits TIMEOUT_CYCLES-1.
//               Instantiated only when WB_SPLIT_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_split_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = en && (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/wb_bus_splitter.sv
`default_nettype none
// ============================================================================
// Module      : wb_bus_splitter
// Description : Wishbone classic fan-out of one slave port to NUM_SLAVES
//               peripherals by address-field decode. Optional feature macro
//               WB_SPLIT_TIMEOUT_EN adds hung-slave abort, status slot and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bus_splitter
    import wb_split_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          ADDR_SEL_LSB   = 16,
    parameter int          ADDR_SEL_W     = 4,
    parameter int          SLOT_STRIDE    = 2,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] DEFAULT_DATA   = 32'hDEADBEEF
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            wbs_stb_i,
    input  logic                            wbs_cyc_i,
    input  logic                            wbs_we_i,
    input  logic [3:0]                      wbs_sel_i,
    input  logic [WB_DATA_W-1:0]            wbs_dat_i,
    input  logic [31:0]                     wbs_adr_i,
    output logic                            wbs_ack_o,
    output logic [WB_DATA_W-1:0]            wbs_dat_o,
    output logic [NUM_SLAVES-1:0]           s_stb_o,
    output logic [NUM_SLAVES-1:0]           s_cyc_o,
    input  logic [NUM_SLAVES-1:0]           s_ack_i,
    input  logic [WB_DATA_W*NUM_SLAVES-1:0] s_dat_i,
    output logic [31:0]                     s_adr_o,
    output logic [WB_DATA_W-1:0]            s_dat_o,
    output logic                            s_we_o,
    output logic [3:0]                      s_sel_o,
    output logic                            irq_o
);

    localparam int IDX_W = 3;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 7 ||
        (NUM_SLAVES - 1) * SLOT_STRIDE >= (1 << ADDR_SEL_W) - 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("wb_bus_splitter: illegal parameter combination");
    end

    wb_split_state_t        r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [ADDR_SEL_W-1:0]  w_field;
    logic                   w_req;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_status_hit;
    logic                   w_sel_ack;
    logic [WB_DATA_W-1:0]   w_sel_dat;
    logic                   w_expire;

    assign w_field = wbs_adr_i[ADDR_SEL_LSB +: ADDR_SEL_W];
    assign w_req   = wbs_stb_i & wbs_cyc_i;

    assign s_adr_o = wbs_adr_i;
    assign s_dat_o = wbs_dat_i;
    assign s_we_o  = wbs_we_i;
    assign s_sel_o = wbs_sel_i;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_sel_ack = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_field == ADDR_SEL_W'(k * SLOT_STRIDE)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(k);
            end
            if (r_idx == IDX_W'(k)) begin
                w_sel_ack = s_ack_i[k];
                w_sel_dat = s_dat_i[k*WB_DATA_W +: WB_DATA_W];
            end
        end
    end

`ifdef WB_SPLIT_TIMEOUT_EN
    logic                 r_to_flag;
    logic [IDX_W-1:0]     r_last_idx;
    logic [WB_DATA_W-1:0] w_status;

    assign w_status_hit = (w_field == STATUS_SLOT[ADDR_SEL_W-1:0]);

    // Counter is held clear everywhere but ACTIVE, so each transaction starts from zero
    wb_split_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (r_state != ST_ACTIVE),
        .en       (r_state == ST_ACTIVE),
        .expire   (w_expire)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_to_flag  <= 1'b0;
            r_last_idx <= '0;
        end else if (r_state == ST_TOUT) begin
            r_to_flag  <= 1'b1;
            r_last_idx <= r_idx;
        end else if (r_state == ST_STAT && wbs_we_i && wbs_sel_i[0] && wbs_dat_i[0]) begin
            r_to_flag  <= 1'b0;
        end
    end

    always_comb begin
        w_status                       = '0;
        w_status[TMO_LSB +: 16]        = 16'(TIMEOUT_CYCLES);
        w_status[LAST_IDX_LSB +: IDX_W] = r_last_idx;
        w_status[TO_FLAG_BIT]          = r_to_flag;
    end

    assign irq_o = r_to_flag;
`else
    assign w_status_hit = 1'b0;
    assign w_expire     = 1'b0;
    assign irq_o        = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            r_idx   <= w_hit_idx;
                            r_state <= ST_ACTIVE;
                        end else if (w_status_hit) begin
                            r_state <= ST_STAT;
                        end else begin
                            r_state <= ST_UNMAP;
                        end
                    end
                end
                // Slave ack has priority over a same-cycle expiry
                ST_ACTIVE: begin
                    if (w_sel_ack || !wbs_cyc_i) begin
                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_state <= ST_TOUT;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wbs_ack_o = 1'b0;
        wbs_dat_o = DEFAULT_DATA;
        s_stb_o   = '0;
        s_cyc_o   = '0;
        case (r_state)
            ST_ACTIVE: begin
                for (int k = 0; k < NUM_SLAVES; k++) begin
                    if (r_idx == IDX_W'(k)) begin
                        s_stb_o[k] = wbs_stb_i;
                        s_cyc_o[k] = wbs_cyc_i;
                    end
                end
                wbs_ack_o = w_sel_ack;
                wbs_dat_o = w_sel_dat;
            end
            ST_UNMAP, ST_TOUT: wbs_ack_o = 1'b1;
            ST_STAT: begin
                wbs_ack_o = 1'b1;
`ifdef WB_SPLIT_TIMEOUT_EN
                wbs_dat_o = w_status;
`endif
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_bus_splitter
// Description : Scoreboard bench for wb_bus_splitter at default parameters;
//               timeout/status scenarios run when WB_SPLIT_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_bus_splitter;

    localparam int          NS  = 4;
    localparam logic [31:0] DEF = 32'hDEADBEEF;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]      wbs_sel_i = 4'h0;
    logic [31:0]     wbs_dat_i = '0, wbs_adr_i = '0;
    logic            wbs_ack_o;
    logic [31:0]     wbs_dat_o;
    logic [NS-1:0]   s_stb_o, s_cyc_o;
    logic [NS-1:0]   s_ack_i = '0;
    logic [32*NS-1:0] s_dat_i = '0;
    logic [31:0]     s_adr_o, s_dat_o;
    logic            s_we_o;
    logic [3:0]      s_sel_o;
    logic            irq_o;

    wb_bus_splitter dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .s_stb_o   (s_stb_o),
        .s_cyc_o   (s_cyc_o),
        .s_ack_i   (s_ack_i),
        .s_dat_i   (s_dat_i),
        .s_adr_o   (s_adr_o),
        .s_dat_o   (s_dat_o),
        .s_we_o    (s_we_o),
        .s_sel_o   (s_sel_o),
        .irq_o     (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] q_dat[$];
    int          q_lat[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One master access; cycle 0 is the first cycle the request is visible.
    // ack_cyc < 0 means the addressed slave never acks.
    task automatic access(input string tag, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input int slv, input int ack_cyc,
                          input logic [31:0] sdat, input logic [31:0] exp_dat,
                          input int exp_lat, input logic [3:0] exp_stb,
                          input logic [3:0] exp_stb_ack);
        logic [31:0] e_dat;
        int          e_lat;
        bit          done;
        done = 1'b0;
        q_dat.push_back(exp_dat);
        q_lat.push_back(exp_lat);
        @(posedge wb_clk_i); #1;
        wbs_adr_i = adr;  wbs_we_i  = we;  wbs_dat_i = wdat;
        wbs_sel_i = 4'hF; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        if (slv >= 0) s_dat_i[slv*32 +: 32] = sdat;
        for (int c = 0; c < 400 && !done; c++) begin
            s_ack_i = '0;
            if (slv >= 0 && c == ack_cyc) s_ack_i[slv] = 1'b1;
            @(negedge wb_clk_i);
            if (c == 0) chk({tag, ".adr_copy"}, s_adr_o, adr);
            if (c == 1) chk({tag, ".stb"}, {28'd0, s_stb_o}, {28'd0, exp_stb});
            if (wbs_ack_o) begin
                e_dat = q_dat.pop_front();
                e_lat = q_lat.pop_front();
                chk({tag, ".dat"}, wbs_dat_o, e_dat);
                chk({tag, ".lat"}, 32'(c), 32'(e_lat));
                chk({tag, ".stb_at_ack"}, {28'd0, s_stb_o}, {28'd0, exp_stb_ack});
                done = 1'b1;
            end
            @(posedge wb_clk_i); #1;
        end
        if (!done) begin
            chk({tag, ".no_ack_within_bound"}, 32'd0, 32'd1);
            q_dat.delete();
            q_lat.delete();
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; s_ack_i = '0;
    endtask

    initial begin
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst.ack", {31'd0, wbs_ack_o}, 32'd0);
        chk("rst.stb", {28'd0, s_stb_o}, 32'd0);
        chk("rst.cyc", {28'd0, s_cyc_o}, 32'd0);
        chk("rst.irq", {31'd0, irq_o}, 32'd0);
        chk("rst.dat", wbs_dat_o, DEF);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;

        access("rd_s1",    32'h3002_0000, 1'b0, 32'h0,    1, 3,  32'h1234_5678, 32'h1234_5678, 3, 4'b0010, 4'b0010);
        access("wr_unmap", 32'h3001_0000, 1'b1, 32'hA5A5, -1, -1, 32'h0,        DEF,           1, 4'b0000, 4'b0000);
        access("rd_s0",    32'h3000_0000, 1'b0, 32'h0,    0, 1,  32'hCAFE_F00D, 32'hCAFE_F00D, 1, 4'b0001, 4'b0001);

`ifdef WB_SPLIT_TIMEOUT_EN
        access("rd_s2_hang", 32'h3004_0000, 1'b0, 32'h0, 2, -1, 32'h0, DEF, 256, 4'b0100, 4'b0000);
        @(negedge wb_clk_i);
        chk("hang.irq", {31'd0, irq_o}, 32'd1);
        access("rd_stat",  32'h300F_0000, 1'b0, 32'h0, -1, -1, 32'h0, 32'h00FF_0201, 1, 4'b0000, 4'b0000);
        access("clr_stat", 32'h300F_0000, 1'b1, 32'h1, -1, -1, 32'h0, 32'h00FF_0201, 1, 4'b0000, 4'b0000);
        @(negedge wb_clk_i);
        chk("clr.irq", {31'd0, irq_o}, 32'd0);
        access("rd_stat2", 32'h300F_0000, 1'b0, 32'h0, -1, -1, 32'h0, 32'h00FF_0200, 1, 4'b0000, 4'b0000);
        access("ack_254",  32'h3006_0000, 1'b0, 32'h0, 3, 255, 32'h0BAD_C0DE, 32'h0BAD_C0DE, 255, 4'b1000, 4'b1000);
        access("rd_stat3", 32'h300F_0000, 1'b0, 32'h0, -1, -1, 32'h0, 32'h00FF_0200, 1, 4'b0000, 4'b0000);
        @(negedge wb_clk_i);
        chk("ack_254.irq", {31'd0, irq_o}, 32'd0);
`else
        access("stat_unmap", 32'h300F_0000, 1'b0, 32'h0, -1, -1, 32'h0, DEF, 1, 4'b0000, 4'b0000);
        @(negedge wb_clk_i);
        chk("stat_unmap.irq", {31'd0, irq_o}, 32'd0);
`endif

        // Reset pulsed in cycle 2 of a pending slave-0 access
        @(posedge wb_clk_i); #1;
        wbs_adr_i = 32'h3000_0000; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        chk("rstmid.stb_c1", {28'd0, s_stb_o}, 32'd1);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rstmid.stb_c3", {28'd0, s_stb_o}, 32'd0);
        chk("rstmid.ack_c3", {31'd0, wbs_ack_o}, 32'd0);
        access("after_rst", 32'h3000_0000, 1'b0, 32'h0, 0, 2, 32'h5555_AAAA, 32'h5555_AAAA, 2, 4'b0001, 4'b0001);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
